window_scan_ctrl: RTL and testbench

//  Sequences one frame of normalized HOG blocks into the block line buffer that forms 4x8-block detection windows.

---
 rtl/window_scan_ctrl.sv | 117 +++++++++++
 tb/tb_window_scan_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl.sv
// Frame sequencer between the HOG block normalizer and the detection-window classifier.
// Walks the block raster, strobes the block line buffer and raises one window per interior block.
module window_scan_ctrl #(
    parameter int BLOCK_COLS = 40,
    parameter int BLOCK_ROWS = 30,
    parameter int WIN_COLS   = 4,
    parameter int WIN_ROWS   = 8,
    localparam int XW   = $clog2(BLOCK_COLS),
    localparam int YW   = $clog2(BLOCK_ROWS),
    localparam int NWIN = (BLOCK_COLS - WIN_COLS + 1) * (BLOCK_ROWS - WIN_ROWS + 1),
    localparam int CW   = $clog2(NWIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          frame_abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          buf_push,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic [CW-1:0] win_count,
    output logic          busy,
    output logic          frame_done
);

    // Both handshakes (in_valid/in_ready, win_valid/win_ready) transfer on a cycle where
    // valid and ready are both high; valid never depends on ready, and a raised win_valid
    // keeps its coordinates stable until it is taken.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [XW-1:0] COL_LAST = XW'(BLOCK_COLS - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(BLOCK_ROWS - 1);
    localparam logic [XW-1:0] X_OFS    = XW'(WIN_COLS - 1);
    localparam logic [YW-1:0] Y_OFS    = YW'(WIN_ROWS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NWIN);

    state_t          state;
    state_t          state_next;
    logic [XW-1:0]   blk_col;
    logic [YW-1:0]   blk_row;
    logic            accept;
    logic            last_blk;
    logic            completes;

    always_comb begin
        in_ready   = (state == SCAN) && (!win_valid || win_ready);
        accept     = in_valid && in_ready;
        buf_push   = accept;
        last_blk   = (blk_col == COL_LAST) && (blk_row == ROW_LAST);
        // A window's bottom-right block has just arrived, so the whole window is buffered.
        completes  = accept && (blk_col >= X_OFS) && (blk_row >= Y_OFS);
        busy       = (state != IDLE);
        frame_done = (state == DONE);

        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = SCAN;
            SCAN:    if (accept && last_blk) state_next = DRAIN;
            DRAIN:   if (win_valid && win_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (frame_abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            blk_col   <= '0;
            blk_row   <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            win_count <= '0;
        end else begin
            state <= state_next;
            if (frame_abort) begin
                // Coordinates and win_count are left as they were for post-mortem reads.
                blk_col   <= '0;
                blk_row   <= '0;
                win_valid <= 1'b0;
            end else begin
                if (state == IDLE && frame_start) begin
                    blk_col   <= '0;
                    blk_row   <= '0;
                    win_count <= '0;
                end
                if (accept) begin
                    if (blk_col == COL_LAST) begin
                        blk_col <= '0;
                        blk_row <= blk_row + 1'b1;
                    end else begin
                        blk_col <= blk_col + 1'b1;
                    end
                end
                if (completes) begin
                    win_valid <= 1'b1;
                    win_x     <= blk_col - X_OFS;
                    win_y     <= blk_row - Y_OFS;
                    if (win_count != CNT_MAX) win_count <= win_count + 1'b1;
                end else if (win_valid && win_ready) begin
                    win_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: reset, full frames, backpressure, abort, stray frame_start.
// A block-position model feeds an expected-window queue that every window handshake is checked against.
module tb_window_scan_ctrl;

    localparam int BC = 40;
    localparam int BR = 30;
    localparam int WC = 4;
    localparam int WR = 8;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          frame_abort;
    logic          in_valid;
    logic          in_ready;
    logic          buf_push;
    logic          win_valid;
    logic          win_ready;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic [CW-1:0] win_count;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    window_scan_ctrl #(
        .BLOCK_COLS(BC),
        .BLOCK_ROWS(BR),
        .WIN_COLS(WC),
        .WIN_ROWS(WR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .frame_abort(frame_abort),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .buf_push(buf_push),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_x(win_x),
        .win_y(win_y),
        .win_count(win_count),
        .busy(busy),
        .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    int          m_col, m_row;
    bit          exp_wv, prev_hold;
    logic [XW-1:0] prev_x;
    logic [YW-1:0] prev_y;
    int          n_push, n_hs, n_hs_row0, max_x_row0, n_done, first_idx;
    int          cyc, last_acc_cyc, done_cyc;
    logic [15:0] first_win, last_win;
    logic [CW-1:0] wc_before;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_push = 0; n_hs = 0; n_hs_row0 = 0; max_x_row0 = -1; n_done = 0;
        first_idx = -1; first_win = '1; last_win = '1;
    endtask

    // Scoreboard/model update, called once per cycle at the falling edge.
    task automatic sample();
        bit completing;
        logic [15:0] e;
        logic [15:0] seen;
        cyc++;
        if (rst) begin
            m_col = 0; m_row = 0; exp_q.delete(); exp_wv = 0; prev_hold = 0;
        end else begin
            check("win_valid_seq", win_valid, exp_wv);
            if (prev_hold) begin
                check("hold_x", win_x, prev_x);
                check("hold_y", win_y, prev_y);
            end
            check("buf_push_eq", buf_push, in_valid && in_ready);
            if (win_valid && win_ready) begin
                seen = {8'(win_x), 8'(win_y)};
                if (n_hs == 0) first_win = seen;
                last_win = seen;
                n_hs++;
                if (win_y == 0) begin n_hs_row0++; max_x_row0 = int'(win_x); end
                if (exp_q.size() == 0) check("win_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("win_xy", seen, e);
                end
            end
            completing = buf_push && m_col >= WC - 1 && m_row >= WR - 1;
            if (buf_push) begin
                if (completing) begin
                    if (first_idx < 0) first_idx = n_push;
                    exp_q.push_back({8'(m_col - (WC - 1)), 8'(m_row - (WR - 1))});
                end
                n_push++;
                last_acc_cyc = cyc;
                if (m_col == BC - 1) begin m_col = 0; m_row++; end
                else m_col++;
            end
            if (frame_done) begin n_done++; done_cyc = cyc; end
            exp_wv    = completing || (win_valid && !win_ready);
            prev_hold = win_valid && !win_ready && !completing;
            prev_x    = win_x;
            prev_y    = win_y;
            if (frame_abort) begin
                m_col = 0; m_row = 0; exp_q.delete(); exp_wv = 0; prev_hold = 0;
            end else if (frame_start && !busy) begin
                m_col = 0; m_row = 0; exp_q.delete();
                clear_stats();
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        sample();
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        rise();
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        check("frame_done_seen", 32'(n_done > 0), 1);
        step();
    endtask

    task automatic check_full_frame(input string tag);
        check({tag, "_pushes"}, n_push, 1200);
        check({tag, "_windows"}, n_hs, 851);
        check({tag, "_win_count"}, win_count, 851);
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; m_col = 0; m_row = 0; exp_wv = 0; prev_hold = 0;
        prev_x = '0; prev_y = '0; wc_before = '0; last_acc_cyc = 0; done_cyc = 0;
        clear_stats();
        rst = 1'b1; frame_start = 1'b0; frame_abort = 1'b0; in_valid = 1'b1; win_ready = 1'b0;
        rise();

        // T1: reset held with a block offered
        for (int i = 0; i < 10; i++) begin
            half();
            check("rst_in_ready", in_ready, 0);
            check("rst_buf_push", buf_push, 0);
            check("rst_win_valid", win_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_win_count", win_count, 0);
            check("rst_win_xy", {8'(win_x), 8'(win_y)}, 0);
            rise();
        end
        rst = 1'b0;
        step();
        check("idle_in_ready", in_ready, 0);

        // T2 + T4: full frame, no backpressure
        win_ready = 1'b1;
        start_frame();
        check("t2_busy", busy, 1);
        wait_done(3000);
        check_full_frame("t2");
        check("t2_first_idx", first_idx, 283);
        check("t2_first_win", first_win, 16'h0000);
        check("t2_last_win", last_win, {8'd36, 8'd22});
        check("t2_done_latency", done_cyc - last_acc_cyc, 2);
        check("t4_row0_windows", n_hs_row0, 37);
        check("t4_row0_max_x", max_x_row0, 36);

        // T3: classifier stalls on the first window
        win_ready = 1'b0;
        start_frame();
        begin
            int k;
            k = 0;
            while (!win_valid && k < 400) begin step(); k++; end
        end
        check("t3_first_wv", win_valid, 1);
        for (int i = 0; i < 4; i++) begin
            half();
            check("t3_stall_in_ready", in_ready, 0);
            check("t3_stall_push", buf_push, 0);
            check("t3_stall_xy", {8'(win_x), 8'(win_y)}, 16'h0000);
            rise();
        end
        win_ready = 1'b1;
        half();
        check("t3_release_push", buf_push, 1);
        rise();
        half();
        check("t3_next_wv", win_valid, 1);
        check("t3_next_xy", {8'(win_x), 8'(win_y)}, {8'd1, 8'd0});
        rise();
        begin
            int k;
            k = 0;
            while (n_done == 0 && k < 6000) begin
                win_ready = 1'($urandom_range(0, 1));
                step();
                k++;
            end
        end
        win_ready = 1'b1;
        wait_done(50);
        check_full_frame("t3");

        // T5: abort mid-frame, then abort racing frame_start, then a clean frame
        start_frame();
        begin
            int k;
            k = 0;
            while (n_push < 499 && k < 2000) begin step(); k++; end
        end
        frame_abort = 1'b1;
        half();
        check("t5_abort_push", buf_push, 1);
        wc_before = win_count;
        rise();
        frame_abort = 1'b0;
        half();
        check("t5_busy", busy, 0);
        check("t5_win_valid", win_valid, 0);
        check("t5_in_ready", in_ready, 0);
        check("t5_no_done", frame_done, 0);
        check("t5_count_held", win_count, wc_before);
        check("t5_count_nonzero", 32'(wc_before != 0), 1);
        rise();
        frame_start = 1'b1;
        frame_abort = 1'b1;
        step();
        frame_start = 1'b0;
        frame_abort = 1'b0;
        half();
        check("t5_race_idle", busy, 0);
        check("t5_race_count", win_count, wc_before);
        rise();
        start_frame();
        wait_done(3000);
        check_full_frame("t5");

        // T6: stray frame_start during SCAN
        start_frame();
        for (int i = 0; i < 300; i++) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("t6_busy", busy, 1);
        wait_done(3000);
        check_full_frame("t6");
        check("t6_last_win", last_win, {8'd36, 8'd22});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
